// File: rtl/pe_act_broadcast_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_act_broadcast_fsm_pkg
// Purpose  : Shared widths and state encoding for the PE activation broadcast
//            block. Holds the default activation, local address and PE index
//            widths, the derived packet width, and the 2-bit FSM encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pe_act_broadcast_fsm_pkg;

  localparam int c_DATA_WIDTH   = 16;
  localparam int c_ACT_NO_WIDTH = 6;
  localparam int c_PE_IDX_WIDTH = 6;
  localparam int c_ADDR_WIDTH   = c_ACT_NO_WIDTH + c_PE_IDX_WIDTH;
  localparam int c_PKT_WIDTH    = c_ADDR_WIDTH + c_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } bcast_state_e;

  // Packet layout is {local_addr, pe_idx, value}; the upper two fields form
  // the absolute activation index seen by every PE.
  function automatic int pkt_width(input int act_no_w, input int pe_idx_w,
                                   input int data_w);
    return act_no_w + pe_idx_w + data_w;
  endfunction

endpackage : pe_act_broadcast_fsm_pkg
`default_nettype wire

// File: rtl/pe_act_broadcast_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_act_broadcast_fsm_if
// Purpose  : Valid/ready broadcast bus carrying {abs_idx, value} packets from
//            a PE's activation scanner to the activation queues of all PEs.
// Signals  : bcast_valid  packet valid (driven by master)
//            bcast_data   {abs_idx, value} (driven by master)
//            bcast_ready  network accepts when valid & ready (driven by slave)
// Note     : PKT_WIDTH must equal ACT_NO_WIDTH+PE_IDX_WIDTH+DATA_WIDTH of the
//            attached pe_act_broadcast_fsm.
// Revision : 1.0 - initial release
// ============================================================================
interface pe_act_broadcast_fsm_if
  import pe_act_broadcast_fsm_pkg::*;
#(
  parameter int PKT_WIDTH = c_PKT_WIDTH
) ();

  logic                 bcast_valid;
  logic [PKT_WIDTH-1:0] bcast_data;
  logic                 bcast_ready;

  modport master (
    output bcast_valid,
    output bcast_data,
    input  bcast_ready
  );

  modport slave (
    input  bcast_valid,
    input  bcast_data,
    output bcast_ready
  );

endinterface : pe_act_broadcast_fsm_if
`default_nettype wire

// File: rtl/pe_bcast_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pe_bcast_skid_buffer
// Purpose  : 2-entry valid/ready buffer between the register-file read return
//            and the broadcast network. The head entry is a register that
//            drives the output directly, so out_data is stable while stalled.
// Ports    : clk, rst          clock, synchronous active-high reset
//            push, push_data   write one entry
//            pop               consume head (ignored when empty)
//            out_valid         head entry present
//            out_data          head entry contents
//            count             occupancy 0..2
// Revision : 1.0 - initial release
// ============================================================================
module pe_bcast_skid_buffer #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop     = pop && (r_count != 2'd0);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= push_data;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= push_data;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry goes behind whatever remains.
          if (r_count == 2'd1) begin
            r_head <= push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= push_data;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // The upstream credit scheme must never push into a full, stalled buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !w_pop && (r_count == 2'd2)));

endmodule : pe_bcast_skid_buffer
`default_nettype wire

// File: rtl/pe_act_broadcast_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pe_act_broadcast_fsm
// Purpose  : On a per-layer start pulse, scans this PE's slice of the input
//            activation register file, drops zero values and broadcasts each
//            nonzero value as {abs_idx, value} with abs_idx = {addr, PE_IDX}.
//            Pulses local_bcast_done once the whole slice has been sent.
// Ports    : clk, rst             clock, synchronous active-high reset
//            PE_IDX               static PE index
//            pe_start_broadcast   1-cycle layer start pulse
//            in_act_no            local activation count, sampled with start
//            act_rd_en/addr/data  register-file read port (1-cycle latency)
//            bcast                broadcast bus (master side)
//            local_bcast_done     1-cycle pulse when the slice is fully sent
//            busy                 high in any state other than IDLE
// Revision : 1.0 - initial release
// ============================================================================
module pe_act_broadcast_fsm
  import pe_act_broadcast_fsm_pkg::*;
#(
  parameter int DATA_WIDTH   = c_DATA_WIDTH,
  parameter int ACT_NO_WIDTH = c_ACT_NO_WIDTH,
  parameter int PE_IDX_WIDTH = c_PE_IDX_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PE_IDX_WIDTH-1:0] PE_IDX,
  input  logic                    pe_start_broadcast,
  input  logic [ACT_NO_WIDTH:0]   in_act_no,
  output logic                    act_rd_en,
  output logic [ACT_NO_WIDTH-1:0] act_rd_addr,
  input  logic [DATA_WIDTH-1:0]   act_rd_data,
  pe_act_broadcast_fsm_if.master  bcast,
  output logic                    local_bcast_done,
  output logic                    busy
);

  localparam int ADDR_WIDTH = ACT_NO_WIDTH + PE_IDX_WIDTH;
  localparam int PKT_WIDTH  = pkt_width(ACT_NO_WIDTH, PE_IDX_WIDTH, DATA_WIDTH);

  bcast_state_e            r_state;
  bcast_state_e            w_state_nxt;
  logic [ACT_NO_WIDTH:0]   r_act_no;
  logic [ACT_NO_WIDTH:0]   w_act_no_nxt;
  logic [ACT_NO_WIDTH:0]   r_rd_ptr;
  logic [ACT_NO_WIDTH:0]   w_rd_ptr_nxt;
  logic [ACT_NO_WIDTH:0]   w_rd_ptr_inc;
  logic                    r_inflight;
  logic [ACT_NO_WIDTH-1:0] r_rd_addr_d1;

  logic                    w_issue;
  logic                    w_done;
  logic                    w_credit_ok;
  logic                    w_push;
  logic                    w_pop;
  logic [PKT_WIDTH-1:0]    w_push_data;
  logic                    w_skid_valid;
  logic [PKT_WIDTH-1:0]    w_skid_data;
  logic [1:0]              w_skid_count;
  logic [ADDR_WIDTH-1:0]   w_abs_idx;

  // --------------------------------------------------------------------------
  // Read return path: zero activations are dropped without touching the
  // buffer. The index comes from the address that produced this data.
  // --------------------------------------------------------------------------
  assign w_abs_idx   = {r_rd_addr_d1, PE_IDX};
  assign w_push      = r_inflight && (act_rd_data != '0);
  assign w_push_data = {w_abs_idx, act_rd_data};
  assign w_pop       = w_skid_valid && bcast.bcast_ready;

  // Credit: the read issued now lands next cycle, so the in-flight read plus
  // the buffer contents left after this cycle's pop must leave a free slot.
  // Pop is only true with a non-empty buffer, so the subtraction cannot wrap.
  assign w_credit_ok = (({1'b0, r_inflight} + w_skid_count) - {1'b0, w_pop})
                       <= 2'd1;

  assign w_rd_ptr_inc = r_rd_ptr + {{ACT_NO_WIDTH{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // FSM next-state and control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_act_no_nxt = r_act_no;
    w_rd_ptr_nxt = r_rd_ptr;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pe_start_broadcast) begin
          w_act_no_nxt = in_act_no;
          w_rd_ptr_nxt = '0;
          w_state_nxt  = (in_act_no == '0) ? ST_DRAIN : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_credit_ok) begin
          w_issue      = 1'b1;
          w_rd_ptr_nxt = w_rd_ptr_inc;
          // The pointer is one bit wider than the address, so a full count
          // of 2^ACT_NO_WIDTH compares equal here instead of wrapping.
          if (w_rd_ptr_inc == r_act_no) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!r_inflight && (w_skid_count == 2'd0)) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_act_no     <= '0;
      r_rd_ptr     <= '0;
      r_inflight   <= 1'b0;
      r_rd_addr_d1 <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_act_no   <= w_act_no_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_addr_d1 <= r_rd_ptr[ACT_NO_WIDTH-1:0];
      end
    end
  end

  pe_bcast_skid_buffer #(
    .WIDTH (PKT_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .out_valid (w_skid_valid),
    .out_data  (w_skid_data),
    .count     (w_skid_count)
  );

  assign act_rd_en         = w_issue;
  assign act_rd_addr       = r_rd_ptr[ACT_NO_WIDTH-1:0];
  assign bcast.bcast_valid = w_skid_valid;
  assign bcast.bcast_data  = w_skid_data;
  assign local_bcast_done  = w_done;
  assign busy              = (r_state != ST_IDLE);

  // A start while busy is ignored by the FSM; flag it in simulation.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(pe_start_broadcast && busy));

endmodule : pe_act_broadcast_fsm
`default_nettype wire

// File: tb/tb_pe_act_broadcast_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_act_broadcast_fsm
// Purpose  : Directed self-checking bench for pe_act_broadcast_fsm. Cycle c
//            is the interval after the c-th rising edge following the edge
//            that samples the start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_act_broadcast_fsm;
  import pe_act_broadcast_fsm_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int PW   = 6;
  localparam int PKTW = AW + PW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pe_idx;
  logic          start;
  logic [AW:0]   in_act_no;
  logic          act_rd_en;
  logic [AW-1:0] act_rd_addr;
  logic [DW-1:0] act_rd_data = '0;
  logic          local_bcast_done;
  logic          busy;

  always #5 clk = ~clk;

  pe_act_broadcast_fsm_if #(.PKT_WIDTH(PKTW)) bus ();

  pe_act_broadcast_fsm #(
    .DATA_WIDTH   (DW),
    .ACT_NO_WIDTH (AW),
    .PE_IDX_WIDTH (PW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .PE_IDX             (pe_idx),
    .pe_start_broadcast (start),
    .in_act_no          (in_act_no),
    .act_rd_en          (act_rd_en),
    .act_rd_addr        (act_rd_addr),
    .act_rd_data        (act_rd_data),
    .bcast              (bus),
    .local_bcast_done   (local_bcast_done),
    .busy               (busy)
  );

  // Register-file model: one-cycle read latency.
  logic [DW-1:0] mem [64];
  always @(posedge clk) if (act_rd_en) act_rd_data <= mem[act_rd_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observations from one layer run
  logic [PKTW-1:0] pkt_q [$];
  int              pkt_cyc [$];
  int rd_cnt, rd_before_hi, done_cnt, done_cyc, stable_err;
  logic busy_at_rst, valid_at_rst;

  function automatic logic [PKTW-1:0] mk(input int addr, input int val);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    a = addr[AW-1:0];
    v = val[DW-1:0];
    return {a, pe_idx, v};
  endfunction

  function automatic logic [PKTW-1:0] pkt_at(input int i);
    if (i < pkt_q.size()) return pkt_q[i];
    return '1;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < pkt_cyc.size()) return pkt_cyc[i];
    return -1;
  endfunction

  // Run one layer: ready low for cycles lo..hi, reset driven during rst_at.
  task automatic run_layer(input int n, input int lo, input int hi,
                           input int rst_at, input int budget);
    logic [PKTW-1:0] prev;
    logic            prev_stall;
    pkt_q.delete();
    pkt_cyc.delete();
    rd_cnt = 0; rd_before_hi = 0; done_cnt = 0; done_cyc = -1;
    stable_err = 0; prev_stall = 1'b0; prev = '0;
    busy_at_rst = 1'b1; valid_at_rst = 1'b1;
    @(negedge clk);
    in_act_no = n[AW:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      bus.bcast_ready = !(c >= lo && c <= hi);
      rst = (c == rst_at);
      @(negedge clk);
      if (bus.bcast_valid && bus.bcast_ready) begin
        pkt_q.push_back(bus.bcast_data);
        pkt_cyc.push_back(c);
      end
      if (prev_stall && bus.bcast_valid && (bus.bcast_data != prev)) stable_err++;
      if (prev_stall && !bus.bcast_valid) stable_err++;
      prev_stall = bus.bcast_valid && !bus.bcast_ready;
      prev = bus.bcast_data;
      if (act_rd_en) begin
        rd_cnt++;
        if (c <= hi) rd_before_hi++;
      end
      if (local_bcast_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == rst_at + 1) begin
        busy_at_rst  = busy;
        valid_at_rst = bus.bcast_valid;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.bcast_ready = 1'b1;
  endtask

  task automatic check_first_scenario(input string p);
    check({p, "_rd_cnt"},   rd_cnt, 4);
    check({p, "_pkt_cnt"},  pkt_q.size(), 4);
    check({p, "_pkt0"},     pkt_at(0), {6'd0, 6'd3, 16'd5});
    check({p, "_pkt1"},     pkt_at(1), {6'd1, 6'd3, 16'd7});
    check({p, "_pkt2"},     pkt_at(2), {6'd2, 6'd3, 16'd9});
    check({p, "_pkt3"},     pkt_at(3), {6'd3, 6'd3, 16'd3});
    check({p, "_cyc_first"}, cyc_at(0), 2);
    check({p, "_cyc_last"},  cyc_at(3), 5);
    check({p, "_done_cnt"}, done_cnt, 1);
    check({p, "_done_cyc"}, done_cyc, 6);
  endtask

  initial begin
    int errs;
    rst = 1'b1; start = 1'b0; in_act_no = '0; pe_idx = 6'd3;
    bus.bcast_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", bus.bcast_valid, 0);
    check("rst_data",  bus.bcast_data, 0);
    check("rst_rd_en", act_rd_en, 0);
    check("rst_addr",  act_rd_addr, 0);
    check("rst_done",  local_bcast_done, 0);
    check("rst_busy",  busy, 0);

    // 1: four nonzero values, ready high
    mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd9; mem[3] = 16'd3;
    run_layer(4, -1, -1, -1, 12);
    check_first_scenario("s1");
    check("s1_busy_after", busy, 0);

    // 2: zero skipping
    mem[0] = 16'd0; mem[1] = 16'd4; mem[2] = 16'd0; mem[3] = 16'd0; mem[4] = 16'd8;
    run_layer(5, -1, -1, -1, 14);
    check("s2_rd_cnt",   rd_cnt, 5);
    check("s2_pkt_cnt",  pkt_q.size(), 2);
    check("s2_pkt0",     pkt_at(0), {6'd1, 6'd3, 16'd4});
    check("s2_pkt1",     pkt_at(1), {6'd4, 6'd3, 16'd8});
    check("s2_done_cnt", done_cnt, 1);
    check("s2_done_cyc", done_cyc, 7);
    check("s2_done_after_xfer", done_cyc - cyc_at(1), 1);

    // 3: empty slice
    run_layer(0, -1, -1, -1, 6);
    check("s3_rd_cnt",   rd_cnt, 0);
    check("s3_pkt_cnt",  pkt_q.size(), 0);
    check("s3_done_cnt", done_cnt, 1);
    check("s3_done_fast", (done_cyc >= 0 && done_cyc < 2), 1);
    check("s3_busy_after", busy, 0);

    // 4: backpressure on cycles 2..6
    mem[0] = 16'd11; mem[1] = 16'd22; mem[2] = 16'd33; mem[3] = 16'd44;
    run_layer(4, 2, 6, -1, 20);
    check("s4_stable",     stable_err, 0);
    check("s4_rd_stall",   rd_before_hi, 2);
    check("s4_rd_cnt",     rd_cnt, 4);
    check("s4_pkt_cnt",    pkt_q.size(), 4);
    check("s4_pkt0",       pkt_at(0), {6'd0, 6'd3, 16'd11});
    check("s4_pkt1",       pkt_at(1), {6'd1, 6'd3, 16'd22});
    check("s4_pkt2",       pkt_at(2), {6'd2, 6'd3, 16'd33});
    check("s4_pkt3",       pkt_at(3), {6'd3, 6'd3, 16'd44});
    check("s4_cyc_first",  cyc_at(0), 7);
    check("s4_done_cnt",   done_cnt, 1);
    check("s4_done_cyc",   done_cyc, 11);

    // 5: full 64-entry slice
    for (int i = 0; i < 64; i++) mem[i] = DW'(i + 1);
    run_layer(64, -1, -1, -1, 80);
    errs = 0;
    for (int i = 0; i < 64; i++) if (pkt_at(i) != mk(i, i + 1)) errs++;
    check("s5_rd_cnt",   rd_cnt, 64);
    check("s5_pkt_cnt",  pkt_q.size(), 64);
    check("s5_order",    errs, 0);
    check("s5_pkt63",    pkt_at(63), {6'd63, 6'd3, 16'd64});
    check("s5_done_cnt", done_cnt, 1);
    check("s5_done_cyc", done_cyc, 66);

    // 6: reset during cycle 3, then a fresh run
    mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd9; mem[3] = 16'd3;
    run_layer(4, -1, -1, 3, 12);
    check("s6_busy_rst",  busy_at_rst, 0);
    check("s6_valid_rst", valid_at_rst, 0);
    check("s6_no_done",   done_cnt, 0);
    run_layer(4, -1, -1, -1, 12);
    check_first_scenario("s6r");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pe_act_broadcast_fsm
`default_nettype wire
